// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, HALTED, FAULT} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with push, pop and flush; head is the oldest entry.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type T = fetch_entry_t,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              din,
    output T              head,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    T mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic [PW-1:0] rd_nxt, wr_nxt;
    assign rd_nxt = (rd == PW'(DEPTH - 1)) ? '0 : rd + 1'b1;
    assign wr_nxt = (wr == PW'(DEPTH - 1)) ? '0 : wr + 1'b1;
    assign head = mem[rd];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            rd    <= pop ? rd_nxt : rd;
            wr    <= push ? wr_nxt : wr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC register, fetch FSM and FIFO control feeding decode over valid/ready.
// Define FETCH_BOUNDS_CHECK_EN to fault when the PC leaves the MEM_SIZE-word instr_mem.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_SIZE  = 256,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  fetch_state,
    output logic        fault
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    fetch_state_t  state, state_nxt;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    logic          push, pop, push_ok, oob;
    assign oob       = BOUNDS_EN && ({2'b00, pc[31:2]} >= 32'(MEM_SIZE));
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = (count < CW'(BUF_DEPTH)) || pop;
    assign imem_addr   = pc;
    assign out_instr   = out_valid ? head.instr : NOP_INSTR;
    assign out_pc      = out_valid ? head.pc : '0;
    assign fetch_state = state;
    assign fault       = state == FAULT;
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        if (redirect_valid) begin
            state_nxt = halt_req ? HALTED : FETCH;
        end else if (state == FETCH) begin
            state_nxt = halt_req ? HALTED : (oob ? FAULT : FETCH);
            push      = !halt_req && !oob && push_ok;
        end else if (state == HALTED) begin
            state_nxt = halt_req ? HALTED : FETCH;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= redirect_valid ? (redirect_pc & ~32'h3) : (push ? pc + 32'd4 : pc);
        end
    end
    fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{pc: pc, instr: imem_instr}),
        .head  (head),
        .count (count)
    );
endmodule
